// File: rtl/lcd_sequencer.sv
// lcd_sequencer: power-up/init command sequencing and request arbitration for the character-LCD mux.
// Optional feature macro LCD_REINIT_EN adds a `reinit` input that reruns the init steps from IDLE.
module lcd_sequencer #(
  parameter int T_POWERUP = 750000,
  parameter int T_EN      = 12,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_req,
  input  logic       enhe_req,
  input  logic       char_valid,
  input  logic [6:0] char_d,
`ifdef LCD_REINIT_EN
  input  logic       reinit,
`endif
  output logic       req_ready,
  output logic [2:0] grant,
  output logic [2:0] scrinit,
  output logic       init,
  output logic       creaenhe,
  output logic [6:0] d_out,
  output logic       lcd_e,
  output logic       init_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_PWR   = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_IDLE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             in_init_r;
  logic [CNT_W-1:0] wait_last_s;
  logic             reinit_s;

`ifdef LCD_REINIT_EN
  assign reinit_s = reinit;
`else
  assign reinit_s = 1'b0;
`endif

  // Init command order: 101 -> 001 -> 010 -> 011 -> 100.
  function automatic logic [2:0] next_step(input logic [2:0] cur);
    case (cur)
      3'b101:  next_step = 3'b001;
      3'b001:  next_step = 3'b010;
      3'b010:  next_step = 3'b011;
      3'b011:  next_step = 3'b100;
      default: next_step = 3'b000;
    endcase
  endfunction

  // Post-strobe wait length: clears (init step 100 or user clear) need the long wait.
  always_comb begin
    wait_last_s = CNT_W'(T_CMD - 1);
    if (init || (scrinit == 3'b100)) begin
      wait_last_s = CNT_W'(T_CLEAR - 1);
    end else begin
      wait_last_s = CNT_W'(T_CMD - 1);
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_PWR;
      cnt_r     <= '0;
      in_init_r <= 1'b1;
      scrinit   <= 3'b000;
      init      <= 1'b0;
      creaenhe  <= 1'b0;
      d_out     <= 7'h00;
      lcd_e     <= 1'b0;
      req_ready <= 1'b0;
      grant     <= 3'b000;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      grant <= 3'b000;
      case (state_r)
        ST_PWR: begin
          if (cnt_r == CNT_W'(T_POWERUP - 1)) begin
            cnt_r   <= '0;
            scrinit <= 3'b101;
            state_r <= ST_SETUP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_SETUP: begin
          lcd_e   <= 1'b1;
          cnt_r   <= '0;
          state_r <= ST_PULSE;
        end
        ST_PULSE: begin
          if (cnt_r == CNT_W'(T_EN - 1)) begin
            lcd_e   <= 1'b0;
            cnt_r   <= '0;
            state_r <= ST_WAIT;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (cnt_r == wait_last_s) begin
            cnt_r <= '0;
            if (in_init_r && (scrinit != 3'b100)) begin
              scrinit <= next_step(scrinit);
              state_r <= ST_SETUP;
            end else begin
              // d_out deliberately keeps its last value on return to IDLE.
              scrinit   <= 3'b000;
              init      <= 1'b0;
              creaenhe  <= 1'b0;
              in_init_r <= 1'b0;
              init_done <= 1'b1;
              req_ready <= 1'b1;
              busy      <= 1'b0;
              state_r   <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (reinit_s) begin
            in_init_r <= 1'b1;
            init_done <= 1'b0;
            scrinit   <= 3'b101;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ST_SETUP;
          end else if (clr_req) begin
            grant     <= 3'b100;
            init      <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ST_SETUP;
          end else if (enhe_req) begin
            grant     <= 3'b010;
            creaenhe  <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ST_SETUP;
          end else if (char_valid) begin
            grant     <= 3'b001;
            d_out     <= char_d;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ST_SETUP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_PWR;
          cnt_r     <= '0;
          in_init_r <= 1'b1;
          scrinit   <= 3'b000;
          init      <= 1'b0;
          creaenhe  <= 1'b0;
          lcd_e     <= 1'b0;
          req_ready <= 1'b0;
          init_done <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer: scoreboard of expected grants and strobe-time selects.
module tb_lcd_sequencer;

  localparam int TP  = 10;
  localparam int TE  = 2;
  localparam int TC  = 5;
  localparam int TCL = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_req = 1'b0;
  logic       enhe_req = 1'b0;
  logic       char_valid = 1'b0;
  logic [6:0] char_d = 7'h00;
`ifdef LCD_REINIT_EN
  logic       reinit = 1'b0;
`endif
  logic       req_ready;
  logic [2:0] grant;
  logic [2:0] scrinit;
  logic       init;
  logic       creaenhe;
  logic [6:0] d_out;
  logic       lcd_e;
  logic       init_done;
  logic       busy;

  int compared = 0;
  int mismatched = 0;

  logic [11:0] pulse_q[$];
  logic [2:0]  grant_q[$];
  int          hi_cnt = 0;
  logic        prev_e = 1'b0;
  logic [11:0] exp_p;
  logic [2:0]  exp_g;

  lcd_sequencer #(
    .T_POWERUP(TP), .T_EN(TE), .T_CMD(TC), .T_CLEAR(TCL), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .enhe_req(enhe_req),
    .char_valid(char_valid), .char_d(char_d),
`ifdef LCD_REINIT_EN
    .reinit(reinit),
`endif
    .req_ready(req_ready), .grant(grant), .scrinit(scrinit), .init(init),
    .creaenhe(creaenhe), .d_out(d_out), .lcd_e(lcd_e), .init_done(init_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard monitor: pops expected selects at each strobe rise and expected grants.
  always @(negedge clk) begin
    if (rst) begin
      prev_e = 1'b0;
      hi_cnt = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        check("pulse_expected", pulse_q.size() != 0, 1'b1);
        if (pulse_q.size() != 0) begin
          exp_p = pulse_q.pop_front();
          check("pulse_sel", {scrinit, init, creaenhe, d_out}, exp_p);
        end
      end
      if (lcd_e) hi_cnt++;
      if (!lcd_e && prev_e) begin
        check("pulse_width", hi_cnt, TE);
        hi_cnt = 0;
      end
      if (grant != 3'b000) begin
        check("grant_expected", grant_q.size() != 0, 1'b1);
        if (grant_q.size() != 0) begin
          exp_g = grant_q.pop_front();
          check("grant", grant, exp_g);
        end
      end
      prev_e = lcd_e;
    end
  end

  task automatic push_init(input logic [6:0] d);
    pulse_q.push_back({3'b101, 1'b0, 1'b0, d});
    pulse_q.push_back({3'b001, 1'b0, 1'b0, d});
    pulse_q.push_back({3'b010, 1'b0, 1'b0, d});
    pulse_q.push_back({3'b011, 1'b0, 1'b0, d});
    pulse_q.push_back({3'b100, 1'b0, 1'b0, d});
  endtask

  // Releases reset and follows the init sequence; abort_at > 0 resets mid-run at that cycle.
  task automatic run_init(input int abort_at);
    int cyc;
    int done_cyc;
    pulse_q.delete();
    grant_q.delete();
    push_init(7'h00);
    rst = 1'b0;
    cyc = 0;
    done_cyc = 0;
    while (cyc < 200) begin
      tick();
      cyc++;
      if (cyc == TP - 1) check("pwr_quiet", {lcd_e, scrinit}, 4'b0000);
      if (cyc == TP) check("pwr_step0", scrinit, 3'b101);
      if (init_done && (done_cyc == 0)) done_cyc = cyc;
      if (cyc == abort_at) break;
      if (req_ready) break;
    end
    if (abort_at > 0) begin
      check("abort_pulse_live", {lcd_e, scrinit}, 4'b1011);
      rst = 1'b1;
      tick();
      check("abort_reset_state", {lcd_e, scrinit, init_done, req_ready, busy}, 7'b0000001);
      check("abort_no_done", done_cyc, 0);
    end else begin
      check("init_ready_cycle", cyc, 54);
      check("init_done_cycle", done_cyc, 54);
      check("init_busy", busy, 1'b0);
      check("init_all_steps", pulse_q.size(), 0);
    end
  endtask

  initial begin
    int k;
    int low;
    int init_cnt;
    int enhe_cnt;
    int g_clr;
    int g_enhe;
    int g_chr;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_scrinit", scrinit, 3'b000);
    check("rst_flags", {init, creaenhe, lcd_e, req_ready, init_done, busy}, 6'b000001);
    check("rst_dout", d_out, 7'h00);
    check("rst_grant", grant, 3'b000);

    run_init(0);

    // Single character write
    char_valid = 1'b1;
    char_d = 7'h41;
    grant_q.push_back(3'b001);
    pulse_q.push_back({3'b000, 1'b0, 1'b0, 7'h41});
    tick();
    char_valid = 1'b0;
    char_d = 7'h00;
    check("char_sel", {scrinit, init, creaenhe, d_out, req_ready}, {3'b000, 2'b00, 7'h41, 1'b0});
    low = 1;
    k = 0;
    while (k < 100) begin
      tick();
      k++;
      if (req_ready) break;
      low++;
      check("char_lcd_e", lcd_e, (k == 1) || (k == 2));
    end
    check("char_busy_len", low, 8);
    check("char_dout_hold", d_out, 7'h41);

    // All three requesters at once
    char_d = 7'h33;
    clr_req = 1'b1;
    enhe_req = 1'b1;
    char_valid = 1'b1;
    grant_q.push_back(3'b100);
    grant_q.push_back(3'b010);
    grant_q.push_back(3'b001);
    pulse_q.push_back({3'b000, 1'b1, 1'b0, 7'h41});
    pulse_q.push_back({3'b000, 1'b0, 1'b1, 7'h41});
    pulse_q.push_back({3'b000, 1'b0, 1'b0, 7'h33});
    init_cnt = 0;
    enhe_cnt = 0;
    g_clr = 0;
    g_enhe = 0;
    g_chr = 0;
    k = 0;
    while (k < 200) begin
      tick();
      k++;
      if (init) init_cnt++;
      if (creaenhe) enhe_cnt++;
      if (grant[2]) begin clr_req = 1'b0; g_clr = k; end
      if (grant[1]) begin enhe_req = 1'b0; g_enhe = k; end
      if (grant[0]) begin char_valid = 1'b0; g_chr = k; end
      if (req_ready && (g_chr != 0)) break;
    end
    check("prio_clr_first", g_clr, 1);
    check("prio_gap_clr", g_enhe - g_clr, 13);
    check("prio_gap_enhe", g_chr - g_enhe, 9);
    check("prio_init_len", init_cnt, 12);
    check("prio_enhe_len", enhe_cnt, 8);
    check("prio_dout", d_out, 7'h33);
    check("prio_queues", grant_q.size() + pulse_q.size(), 0);

    // Request raised and dropped during WAIT is ignored
    char_valid = 1'b1;
    char_d = 7'h55;
    grant_q.push_back(3'b001);
    pulse_q.push_back({3'b000, 1'b0, 1'b0, 7'h55});
    tick();
    char_valid = 1'b0;
    k = 0;
    while (k < 100) begin
      tick();
      k++;
      if (k == 4) begin char_valid = 1'b1; char_d = 7'h7f; end
      if (k == 6) char_valid = 1'b0;
      if (req_ready) break;
    end
    check("midwait_ready_len", k, 8);
    repeat (20) tick();
    check("midwait_dout", d_out, 7'h55);
    check("midwait_queues", grant_q.size() + pulse_q.size(), 0);
    check("midwait_idle", {req_ready, busy, lcd_e}, 3'b100);

    // Reset during PULSE of step 011, then a full clean restart
    rst = 1'b1;
    repeat (2) tick();
    run_init(36);
    run_init(0);

`ifdef LCD_REINIT_EN
    reinit = 1'b1;
    pulse_q.delete();
    grant_q.delete();
    push_init(7'h00);
    tick();
    reinit = 1'b0;
    check("reinit_drop", {init_done, req_ready, busy}, 3'b001);
    k = 0;
    while (k < 200) begin
      tick();
      k++;
      if (req_ready) break;
    end
    check("reinit_len", k, 44);
    check("reinit_done", init_done, 1'b1);
    check("reinit_steps", pulse_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
